alu_seq: RTL

- Parametrised successor to the combinational single-cycle ALU.
- Executes the RV32I/RV64I integer ALU ops plus the RV32M/RV64M multiply/divide ops behind a valid/ready handshake.
- ALU ops complete in 1 cycle. MUL*/DIV*/REM* use an iterative radix-2 engine with XLEN+1 cycle latency.
- Sits between decode/operand-read and writeback. One operation is in flight at a time; the result is held until consumed.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_seq_if.sv | 30 +++
 rtl/muldiv_iter.sv | 136 +++++++++++++
 rtl/alu_seq.sv | 101 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 6-bit operation codes (OP_ADD .. OP_REMU)
//   - state_t: control states of the iterative multiply/divide engine
//   - is_muldiv(): true for any MUL*/DIV*/REM* code
package alu_pkg;

  localparam logic [5:0] OP_ADD    = 6'h00;
  localparam logic [5:0] OP_SLT    = 6'h01;
  localparam logic [5:0] OP_SLTU   = 6'h02;
  localparam logic [5:0] OP_AND    = 6'h03;
  localparam logic [5:0] OP_OR     = 6'h04;
  localparam logic [5:0] OP_XOR    = 6'h05;
  localparam logic [5:0] OP_SLL    = 6'h06;
  localparam logic [5:0] OP_SRL    = 6'h07;
  localparam logic [5:0] OP_SUB    = 6'h08;
  localparam logic [5:0] OP_SRA    = 6'h09;
  localparam logic [5:0] OP_MUL    = 6'h10;
  localparam logic [5:0] OP_MULH   = 6'h11;
  localparam logic [5:0] OP_MULHSU = 6'h12;
  localparam logic [5:0] OP_MULHU  = 6'h13;
  localparam logic [5:0] OP_DIV    = 6'h14;
  localparam logic [5:0] OP_DIVU   = 6'h15;
  localparam logic [5:0] OP_REM    = 6'h16;
  localparam logic [5:0] OP_REMU   = 6'h17;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  // 0x10..0x17 share the prefix 3'b010.
  function automatic logic is_muldiv(input logic [5:0] op);
    return op[5:3] == 3'b010;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result handshake bundle for alu_seq.
//   Request : in_valid, in_ready, op, rs1, rs2, imm_val, use_imm
//   Result  : out_valid, out_ready, result, illegal
//   master  : the producer of requests / consumer of results (decode/writeback side)
//   slave   : the ALU itself
interface alu_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm_val;
  logic            use_imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output in_valid, op, rs1, rs2, imm_val, use_imm, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, op, rs1, rs2, imm_val, use_imm, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiply/divide engine.
//   clk, reset : clock, synchronous active-high reset
//   start      : launch an operation (only honoured while idle)
//   op, a, b   : MUL*/DIV*/REM* code and operands, sampled at start
//   idle       : engine is in IDLE and can take a new start
//   done       : high during the FIX cycle; res is valid then
//   res        : sign-corrected result
// The start edge performs the first iteration, so XLEN iterations plus the
// FIX cycle complete XLEN+1 edges after start.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            idle,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  // mul: hi/lo hold the partial product, lo shifting out multiplier bits.
  // div: hi is the partial remainder, lo shifts dividend out and quotient in.
  logic [XLEN-1:0] hi_q, lo_q, d_q;
  logic [5:0]      op_q;
  logic            neg_q, neg_r_q;

  logic            a_signed, b_signed, sa, sb, start_mul, cur_mul;
  logic [XLEN-1:0] ma, mb, cur_hi, cur_lo, cur_d, nhi, nlo;
  logic [XLEN:0]   sum, sh, diff;
  logic [2*XLEN-1:0] prod, prod_s;

  // Operand magnitudes at start.
  always_comb begin
    a_signed  = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed  = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    sa        = a_signed & a[XLEN-1];
    sb        = b_signed & b[XLEN-1];
    ma        = sa ? -a : a;
    mb        = sb ? -b : b;
    // Divide codes have op[2] set, multiply codes clear.
    start_mul = ~op[2];
  end

  // One iteration step, fed either from the start operands or the registers.
  always_comb begin
    cur_mul = start ? start_mul : (state_q == MUL);
    cur_hi  = start ? '0 : hi_q;
    cur_lo  = start ? (start_mul ? mb : ma) : lo_q;
    cur_d   = start ? (start_mul ? ma : mb) : d_q;

    sum  = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_d} : '0);
    sh   = {cur_hi, cur_lo[XLEN-1]};
    diff = sh - {1'b0, cur_d};

    if (cur_mul) begin
      nhi = sum[XLEN:1];
      nlo = {sum[0], cur_lo[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      nhi = diff[XLEN-1:0];
      nlo = {cur_lo[XLEN-2:0], 1'b1};
    end else begin
      // Restoring case: sh < divisor, so bit XLEN of sh is known zero.
      nhi = sh[XLEN-1:0];
      nlo = {cur_lo[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      d_q     <= '0;
      op_q    <= OP_ADD;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= start_mul ? MUL : DIV;
            cnt_q   <= CntW'(1);
            hi_q    <= nhi;
            lo_q    <= nlo;
            d_q     <= cur_d;
            op_q    <= op;
            neg_q   <= sa ^ sb;
            neg_r_q <= sa;
          end
        end
        MUL, DIV: begin
          hi_q <= nhi;
          lo_q <= nlo;
          if (cnt_q == CntLast) begin
            state_q <= FIX;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        FIX:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sign fix-up, consumed by the output register on the FIX edge.
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    case (op_q)
      OP_MUL:                       res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod_s[2*XLEN-1:XLEN];
      OP_DIV:                       res = neg_q ? -lo_q : lo_q;
      OP_DIVU:                      res = lo_q;
      OP_REM:                       res = neg_r_q ? -hi_q : hi_q;
      OP_REMU:                      res = hi_q;
      default:                      res = '0;
    endcase
  end

  assign idle = (state_q == IDLE);
  assign done = (state_q == FIX);

endmodule

// File: rtl/alu_seq.sv
// alu_seq: RV32/64 IM integer ALU with a valid/ready handshake.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : alu_seq_if.slave -- request (op, rs1, rs2/imm_val) and held result
// ALU ops, illegal codes and divide special cases finish in one edge; other
// MUL*/DIV*/REM* ops run on muldiv_iter and finish XLEN+1 edges after accept.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic  clk,
  input  logic  reset,
  alu_seq_if.slave bus
);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0] b, alu_res, md_res, result_q;
  logic [SHW-1:0]  shamt;
  logic            alu_ill, b_zero, ovf, special;
  logic            in_ready, accept, md_start, md_idle, md_done;
  logic            out_valid_q, illegal_q;

  assign b     = bus.use_imm ? bus.imm_val : bus.rs2;
  assign shamt = b[SHW-1:0];

  // Divide cases that the iterative engine does not handle.
  always_comb begin
    b_zero  = (b == '0);
    ovf     = (bus.op inside {OP_DIV, OP_REM}) && (bus.rs1 == MinNeg) && (b == '1);
    special = (bus.op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && (b_zero || ovf);
  end

  assign in_ready = !reset && md_idle && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign md_start = accept && is_muldiv(bus.op) && !special;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (bus.op)
      OP_ADD:  alu_res = bus.rs1 + b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.rs1) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.rs1 < b};
      OP_AND:  alu_res = bus.rs1 & b;
      OP_OR:   alu_res = bus.rs1 | b;
      OP_XOR:  alu_res = bus.rs1 ^ b;
      OP_SLL:  alu_res = bus.rs1 << shamt;
      OP_SRL:  alu_res = bus.rs1 >> shamt;
      OP_SUB:  alu_res = bus.rs1 - b;
      OP_SRA:  alu_res = $signed(bus.rs1) >>> shamt;
      // Only reached through the special cases: divide by zero or overflow.
      OP_DIV, OP_DIVU: alu_res = b_zero ? '1 : bus.rs1;
      OP_REM, OP_REMU: alu_res = b_zero ? bus.rs1 : '0;
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .op    (bus.op),
    .a     (bus.rs1),
    .b     (b),
    .idle  (md_idle),
    .done  (md_done),
    .res   (md_res)
  );

  // Output register; in_ready guarantees a new write never overwrites an
  // unconsumed result.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
    end else if (md_done) begin
      out_valid_q <= 1'b1;
      result_q    <= md_res;
      illegal_q   <= 1'b0;
    end else if (accept && !md_start) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_res;
      illegal_q   <= alu_ill;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.illegal   = illegal_q;

endmodule
